// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter: shares the single-port sprite RAM between the power-up
// initializer, the render fetch path (reads) and the game sprite editor
// (reads and writes).
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_init_*               initializer fill port; it owns the RAM while i_init_busy is high
//   i_rnd_req/addr         render read request; o_rnd_gnt accepts it, o_rnd_rvalid returns it
//   i_gm_req/we/addr/wdata game access; o_gm_gnt accepts it, o_gm_rvalid returns reads
//   o_rdata                shared read data, qualified by the rvalids
//   o_oob_err              sticky flag: a game access was out of bounds
//   o_mem_*, i_mem_rdata   RAM port (synchronous read, data one cycle after the address)
module sprite_mem_arbiter #(
  parameter int unsigned SPRITE_WORDS = 4608,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_busy,
  input  logic        i_init_we,
  input  logic [12:0] i_init_addr,
  input  logic [7:0]  i_init_data,
  input  logic        i_rnd_req,
  input  logic [12:0] i_rnd_addr,
  output logic        o_rnd_gnt,
  output logic        o_rnd_rvalid,
  input  logic        i_gm_req,
  input  logic        i_gm_we,
  input  logic [12:0] i_gm_addr,
  input  logic [7:0]  i_gm_wdata,
  output logic        o_gm_gnt,
  output logic        o_gm_rvalid,
  output logic [7:0]  o_rdata,
  output logic        o_oob_err,
  output logic [12:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_we,
  input  logic [7:0]  i_mem_rdata
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_RND, OWN_GM} owner_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  owner_t            r_own1, r_own2;
  logic              r_oob1, r_oob2;

  logic w_run, w_force, w_gm_gnt, w_rnd_gnt, w_gm_oob;

  // Grants are decided in the request cycle; reset suppresses them immediately.
  assign w_run     = (r_state == S_RUN) && !i_rst;
  assign w_force   = (r_wait_cnt == WAIT_W'(MAX_WAIT)) && i_gm_req;
  assign w_gm_gnt  = w_run && i_gm_req && (!i_rnd_req || w_force);
  assign w_rnd_gnt = w_run && i_rnd_req && !w_gm_gnt;
  assign w_gm_oob  = i_gm_addr >= AW'(SPRITE_WORDS);

  assign o_gm_gnt     = w_gm_gnt;
  assign o_rnd_gnt    = w_rnd_gnt;
  assign o_rnd_rvalid = (r_own2 == OWN_RND);
  assign o_gm_rvalid  = (r_own2 == OWN_GM);
  // Out-of-bounds game reads return zero instead of whatever the RAM drives.
  assign o_rdata      = ((r_own2 != OWN_NONE) && !r_oob2) ? i_mem_rdata : DW'(0);

  // State, RAM issue, return-tag pipeline and starvation counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_wait_cnt  <= '0;
      r_own1      <= OWN_NONE;
      r_own2      <= OWN_NONE;
      r_oob1      <= 1'b0;
      r_oob2      <= 1'b0;
      o_oob_err   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
    end else begin
      r_own2 <= r_own1;
      r_oob2 <= r_oob1;
      r_own1 <= OWN_NONE;
      r_oob1 <= 1'b0;
      case (r_state)
        S_INIT: begin
          o_mem_addr  <= i_init_addr;
          o_mem_wdata <= i_init_data;
          o_mem_we    <= i_init_we && i_init_busy;
          r_wait_cnt  <= '0;
          if (!i_init_busy) r_state <= S_RUN;
        end
        S_RUN: begin
          o_mem_we <= 1'b0;
          if (w_gm_gnt) begin
            o_mem_addr <= i_gm_addr;
            if (i_gm_we) o_mem_wdata <= i_gm_wdata;
            o_mem_we <= i_gm_we && !w_gm_oob;
            r_own1   <= i_gm_we ? OWN_NONE : OWN_GM;
            r_oob1   <= w_gm_oob;
            if (w_gm_oob) o_oob_err <= 1'b1;
          end else if (w_rnd_gnt) begin
            o_mem_addr <= i_rnd_addr;
            r_own1     <= OWN_RND;
          end
          // Count refused cycles of a pending game request, saturating.
          if (!i_gm_req || w_gm_gnt)
            r_wait_cnt <= '0;
          else if (r_wait_cnt != WAIT_W'(MAX_WAIT))
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb_sprite_mem_arbiter: directed bench for sprite_mem_arbiter with a simple
// synchronous-read RAM model attached to the memory port.
module tb_sprite_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_busy, init_we;
  logic [12:0] init_addr;
  logic [7:0]  init_data;
  logic        rnd_req;
  logic [12:0] rnd_addr;
  logic        rnd_gnt, rnd_rvalid;
  logic        gm_req, gm_we;
  logic [12:0] gm_addr;
  logic [7:0]  gm_wdata;
  logic        gm_gnt, gm_rvalid;
  logic [7:0]  rdata;
  logic        oob_err;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [8192];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  sprite_mem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_init_busy(init_busy), .i_init_we(init_we),
    .i_init_addr(init_addr), .i_init_data(init_data),
    .i_rnd_req(rnd_req), .i_rnd_addr(rnd_addr),
    .o_rnd_gnt(rnd_gnt), .o_rnd_rvalid(rnd_rvalid),
    .i_gm_req(gm_req), .i_gm_we(gm_we), .i_gm_addr(gm_addr), .i_gm_wdata(gm_wdata),
    .o_gm_gnt(gm_gnt), .o_gm_rvalid(gm_rvalid),
    .o_rdata(rdata), .o_oob_err(oob_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  // Sprite RAM model: synchronous read, write-first not required.
  initial begin
    ram[4608] = 8'h33;
    ram[8191] = 8'h5A;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      rnd_req = 1'b0;
      gm_req  = 1'b0;
    end
  endtask

  initial begin
    int k;
    int gnt_viol;
    rst = 1'b1; init_busy = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
    rnd_req = 1'b1; rnd_addr = 13'd7; gm_req = 1'b1; gm_we = 1'b0;
    gm_addr = 13'd9; gm_wdata = 8'h00;

    // Reset state, requests held high
    cyc(); cyc(); mid();
    check("rst_rnd_gnt", 32'(rnd_gnt), 32'd0);
    check("rst_gm_gnt", 32'(gm_gnt), 32'd0);
    check("rst_rvalids", 32'({rnd_rvalid, gm_rvalid}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem", 32'({mem_addr, mem_wdata, mem_we}), 32'd0);
    check("rst_oob", 32'(oob_err), 32'd0);

    // Init fill of 0xFF while both clients request
    gnt_viol = 0;
    for (int i = 0; i < 4608; i++) begin
      cyc();
      rst = 1'b0; init_busy = 1'b1; init_we = 1'b1;
      init_addr = 13'(i); init_data = 8'hFF;
      mid();
      if (rnd_gnt || gm_gnt) gnt_viol++;
      if (i > 0 && (i % 1024) == 0) begin
        check("init_mem_addr", 32'(mem_addr), 32'(i - 1));
        check("init_mem_we", 32'(mem_we), 32'd1);
        check("init_mem_wdata", 32'(mem_wdata), 32'hFF);
      end
    end
    check("init_no_gnt", 32'(gnt_viol), 32'd0);

    // Handover: busy falls, still no grant in that cycle
    cyc();
    init_busy = 1'b0; init_we = 1'b0; rnd_req = 1'b1; rnd_addr = 13'd100; gm_req = 1'b0;
    mid();
    check("handover_gnt", 32'({rnd_gnt, gm_gnt}), 32'd0);
    check("last_init_write", 32'({mem_addr, mem_we}), 32'({13'd4607, 1'b1}));
    cyc();
    rnd_req = 1'b0;
    init_busy = 1'b1; init_we = 1'b1; init_addr = 13'd100; init_data = 8'h00;
    mid();
    check("handover_we_off", 32'(mem_we), 32'd0);
    idle(2);

    // Render read of 100
    cyc(); rnd_req = 1'b1; rnd_addr = 13'd100; mid();
    check("rnd_gnt", 32'({rnd_gnt, gm_gnt}), 32'b10);
    cyc(); rnd_req = 1'b0; mid();
    check("rnd_rvalid_t1", 32'(rnd_rvalid), 32'd0);
    check("rnd_mem_addr", 32'(mem_addr), 32'd100);
    check("rnd_mem_we", 32'(mem_we), 32'd0);
    cyc(); mid();
    check("rnd_rvalid_t2", 32'({rnd_rvalid, gm_rvalid}), 32'b10);
    check("rnd_rdata", 32'(rdata), 32'hFF);
    cyc(); mid();
    check("rnd_rvalid_t3", 32'(rnd_rvalid), 32'd0);
    idle(2);

    // Starvation: render continuously, game read of 5 forced through
    cyc();
    rnd_req = 1'b1; rnd_addr = 13'd200; gm_req = 1'b1; gm_we = 1'b0; gm_addr = 13'd5;
    mid();
    k = 0;
    while (!gm_gnt && k < 40) begin
      k++;
      cyc(); mid();
    end
    check("starve_refused", 32'(k), 32'd15);
    check("starve_rnd_gnt", 32'(rnd_gnt), 32'd0);
    cyc(); mid();
    check("starve_cnt_clr_gm", 32'(gm_gnt), 32'd0);
    check("starve_cnt_clr_rnd", 32'(rnd_gnt), 32'd1);
    cyc(); rnd_req = 1'b0; gm_req = 1'b0; mid();
    check("starve_gm_rvalid", 32'({gm_rvalid, rnd_rvalid}), 32'b10);
    check("starve_rdata", 32'(rdata), 32'hFF);
    idle(4);

    // Game write 0x1C to 600, then read it back
    mid();
    check("oob_clear", 32'(oob_err), 32'd0);
    cyc(); gm_req = 1'b1; gm_we = 1'b1; gm_addr = 13'd600; gm_wdata = 8'h1C; mid();
    check("gm_wr_gnt", 32'(gm_gnt), 32'd1);
    cyc(); gm_we = 1'b0; mid();
    check("gm_rd_gnt", 32'(gm_gnt), 32'd1);
    check("gm_wr_issue", 32'({mem_addr, mem_wdata, mem_we}), 32'({13'd600, 8'h1C, 1'b1}));
    cyc(); gm_req = 1'b0; mid();
    check("gm_rvalid_t1", 32'(gm_rvalid), 32'd0);
    cyc(); mid();
    check("gm_rvalid_t2", 32'(gm_rvalid), 32'd1);
    check("gm_rdata", 32'(rdata), 32'h1C);
    idle(2);

    // Out of bounds write 4608 and read 8191
    cyc(); gm_req = 1'b1; gm_we = 1'b1; gm_addr = 13'd4608; gm_wdata = 8'hAA; mid();
    check("oob_wr_gnt", 32'(gm_gnt), 32'd1);
    cyc(); gm_req = 1'b0; mid();
    check("oob_wr_we", 32'(mem_we), 32'd0);
    check("oob_err_set", 32'(oob_err), 32'd1);
    cyc(); gm_req = 1'b1; gm_we = 1'b0; gm_addr = 13'd8191; mid();
    check("oob_rd_gnt", 32'(gm_gnt), 32'd1);
    cyc(); gm_req = 1'b0; mid();
    cyc(); mid();
    check("oob_rd_rvalid", 32'(gm_rvalid), 32'd1);
    check("oob_rd_rdata", 32'(rdata), 32'h00);
    // Render is not bounds-checked: 4608 keeps its preset, the OOB write was dropped
    cyc(); rnd_req = 1'b1; rnd_addr = 13'd4608; mid();
    check("rnd_oob_gnt", 32'(rnd_gnt), 32'd1);
    cyc(); rnd_req = 1'b0; mid();
    cyc(); mid();
    check("rnd_oob_rvalid", 32'(rnd_rvalid), 32'd1);
    check("rnd_oob_rdata", 32'(rdata), 32'h33);
    check("oob_err_sticky", 32'(oob_err), 32'd1);
    idle(2);

    // Reset one cycle after a render grant
    cyc(); rnd_req = 1'b1; rnd_addr = 13'd100; mid();
    check("rr_gnt", 32'(rnd_gnt), 32'd1);
    cyc(); rnd_req = 1'b0; rst = 1'b1; mid();
    cyc(); rnd_req = 1'b1; gm_req = 1'b1; mid();
    check("rr_no_rvalid", 32'({rnd_rvalid, gm_rvalid}), 32'd0);
    check("rr_gnts", 32'({rnd_gnt, gm_gnt}), 32'd0);
    check("rr_rdata", 32'(rdata), 32'd0);
    check("rr_mem", 32'({mem_addr, mem_wdata, mem_we}), 32'd0);
    check("rr_oob", 32'(oob_err), 32'd0);
    cyc(); rst = 1'b0; init_busy = 1'b1; init_we = 1'b0; mid();
    check("rr_init_state", 32'({rnd_gnt, gm_gnt}), 32'd0);
    cyc(); mid();
    check("rr_init_rvalid", 32'({rnd_rvalid, gm_rvalid}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
